// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: default address width, reset PC and next-PC select encoding.
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } next_sel_e;

  typedef enum logic {
    SLOT_IDLE,
    SLOT_PENDING
  } slot_state_e;

endpackage

// File: rtl/jump_target_join.sv
// J-type target: keeps the region bits of pc_plus4 above the index field and appends the word-aligned index.
module jump_target_join #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 26
) (
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [IDX_W-1:0] jump_idx,
  output logic [XLEN-1:0]  target
);

  localparam int REGION_W = XLEN - IDX_W - 2;

  // Low bits of pc_plus4 are replaced by the index, so they never reach the target.
  logic unused_low;
  assign unused_low = ^pc_plus4[IDX_W+1:0];

  generate
    if (REGION_W > 0) begin : g_region
      assign target = {pc_plus4[XLEN-1:IDX_W+2], jump_idx, 2'b00};
    end else begin : g_no_region
      assign target = {jump_idx, 2'b00};
    end
  endgenerate

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with jr > jump > branch redirect selection and stall hold.
// Define DELAY_SLOT_EN to defer each accepted redirect behind one delay-slot instruction.
module pc_redirect_unit #(
  parameter int               XLEN     = cpu_pkg::XLEN,
  parameter int               IDX_W    = 26,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic [IDX_W-1:0] jump_idx,
  input  logic             branch,
  input  logic [15:0]      br_offset,
  input  logic             jr,
  input  logic [XLEN-1:0]  jr_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             slot_pending,
  output logic             misalign,
  output logic [15:0]      redirect_cnt
);

  import cpu_pkg::*;

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] plus4, br_target, j_target, jr_aligned, target;
  logic [15:0]     cnt_reg, cnt_next;
  logic            misalign_reg, misalign_next;
  logic            req, accept;
  next_sel_e       sel;

  assign plus4      = pc_reg + XLEN'(4);
  assign br_target  = plus4 + ({{(XLEN-16){br_offset[15]}}, br_offset} << 2);
  assign jr_aligned = {jr_target[XLEN-1:2], 2'b00};
  assign req        = jr | jump | branch;

  jump_target_join #(
    .XLEN  (XLEN),
    .IDX_W (IDX_W)
  ) u_join (
    .pc_plus4 (plus4),
    .jump_idx (jump_idx),
    .target   (j_target)
  );

  always_comb begin
    sel    = SEL_SEQ;
    target = plus4;
    if (jr) begin
      sel = SEL_JR;
    end else if (jump) begin
      sel = SEL_J;
    end else if (branch) begin
      sel = SEL_BR;
    end
    case (sel)
      SEL_JR:  target = jr_aligned;
      SEL_J:   target = j_target;
      SEL_BR:  target = br_target;
      default: target = plus4;
    endcase
  end

`ifdef DELAY_SLOT_EN
  slot_state_e     state_reg, state_next;
  logic [XLEN-1:0] pend_reg, pend_next;

  // The slot instruction's own requests are dropped: only IDLE can accept.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    pc_next    = pc_reg;
    accept     = 1'b0;
    if (!stall) begin
      case (state_reg)
        SLOT_IDLE: begin
          pc_next = plus4;
          if (req) begin
            accept     = 1'b1;
            pend_next  = target;
            state_next = SLOT_PENDING;
          end
        end
        SLOT_PENDING: begin
          pc_next    = pend_reg;
          state_next = SLOT_IDLE;
        end
        default: state_next = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SLOT_IDLE;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  assign slot_pending = (state_reg == SLOT_PENDING);
`else
  always_comb begin
    accept  = req & ~stall;
    pc_next = pc_reg;
    if (accept) begin
      pc_next = target;
    end else if (!stall) begin
      pc_next = plus4;
    end
  end

  assign slot_pending = 1'b0;
`endif

  assign misalign_next = accept & jr & (|jr_target[1:0]);
  assign cnt_next      = cnt_reg + 16'(accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      cnt_reg      <= '0;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      cnt_reg      <= cnt_next;
      misalign_reg <= misalign_next;
    end
  end

  assign pc           = pc_reg;
  assign pc_plus4     = plus4;
  assign misalign     = misalign_reg;
  assign redirect_cnt = cnt_reg;

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter register and next-PC selector for the CPU fetch stage, the parametrised successor of the fixed 28+4 jump-address concatenation. Holds the current PC and computes sequential, branch, J-type and register-jump targets at configurable width. Applies stall and redirect priority, and optionally models a one-instruction branch delay slot. Sits between decode (redirect requests) and instruction memory (pc).

## Interface
- XLEN, 32: address width.
- IDX_W, 26: J-type instruction-index width; region bits = XLEN-IDX_W-2, must be ≥0.
- RESET_PC, 32'h0000_3000: PC after reset.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  hold PC, pending state and counter this cycle.
- jump  in  1  J/JAL request.
- jump_idx  in  IDX_W  J-type index field.
- branch  in  1  taken conditional branch.
- br_offset  in  16  signed word offset.
- jr  in  1  register jump request.
- jr_target  in  XLEN  register jump address.
- pc  out  XLEN  current fetch address (registered).
- pc_plus4  out  XLEN  pc+4 (combinational from pc).
- slot_pending  out  1  redirect waiting behind a delay slot (registered; tied 0 without macro).
- misalign  out  1  one-cycle pulse: accepted jr with jr_target[1:0]≠0.
- redirect_cnt  out  16  count of accepted redirects.

## Operation
- Reset values: pc=RESET_PC, slot_pending=0, pending target=0, misalign=0, redirect_cnt=0.
- Request priority when several asserted: jr > jump > branch. Decode is expected to assert at most one.
- Targets are computed from pc_plus4 of the requesting instruction:
  - jump: {pc_plus4[XLEN-1:IDX_W+2], jump_idx, 2'b00}.
  - branch: pc_plus4 + (sign_extend(br_offset)<<2), modulo 2^XLEN.
  - jr: {jr_target[XLEN-1:2], 2'b00}; misalign pulses when jr_target[1:0]≠0.
- Sequential: pc <= pc+4; wraps 0xFFFF_FFFC -> 0x0000_0000.
- Stall: pc, pending state and counter hold. A request during stall is ignored; decode re-presents it after the stall. misalign is not pulsed while stalled.
- Accepted redirect (request present, not stalled): redirect_cnt increments, wrapping 0xFFFF->0.

## Timing
- Without delay slot: target loads into pc on the edge ending the request cycle, so redirect latency is 1 cycle.
- With delay slot, a two-state machine IDLE/PENDING:
  - IDLE + accepted redirect -> pc <= pc+4, latch target, go to PENDING (slot_pending=1).
  - PENDING + !stall -> pc <= latched target, return to IDLE. Requests in this cycle (delay-slot instruction) are ignored and not counted.
  - PENDING + stall -> hold.
- rst in any state returns to IDLE with all reset values on the next edge, including mid-PENDING.
- misalign is registered and asserted for exactly the cycle after acceptance.

## Configuration
- DELAY_SLOT_EN defined: IDLE/PENDING delay-slot behaviour as above.
- DELAY_SLOT_EN undefined: no pending register; slot_pending tied 0; immediate redirect.

## Structure
- Shared package cpu_pkg: XLEN, RESET_PC, and typedef enum next_sel_e {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}.
- One sub-module: jump_target_join, the combinational parametrised region/index concatenation. Instantiated once.

## Test plan
- Reset: rst high 2 cycles -> pc=0x3000, pc_plus4=0x3004, slot_pending=0, redirect_cnt=0. Release, 2 free cycles -> pc=0x3008.
- Jump, no macro: pc=0x3008, jump, jump_idx=26'h0000C10 -> next pc=0x0000_3040, redirect_cnt=1.
- Branch loop: pc=0x3010, branch, br_offset=16'hFFFF -> pc stays 0x3010. Wrap: pc=0xFFFF_FFFC free -> 0x0.
- JR misaligned: jr_target=0x0040_0006 -> pc=0x0040_0004, misalign=1 for one cycle. jr+jump together -> jr wins.
- Stall: branch with stall=1 for 3 cycles -> pc, cnt unchanged. Request re-presented with stall=0 -> taken.
- DELAY_SLOT_EN:
  - Jump at 0x3000 to 0x3040 -> pc 0x3004 (slot_pending=1), then 0x3040.
  - Jump in the slot is ignored.
  - rst during PENDING -> pc=0x3000, slot_pending=0.
